// File: rtl/memi_fetch.sv
// Pipelined instruction memory: FETCH_W-wide bundles after LAT cycles, credit-based
// request acceptance, runtime program-load port and front-end flush.
module memi_fetch #(
  parameter int INST_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int FETCH_W = 2,
  parameter int LAT     = 2,
  parameter int WRAP    = 0
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         req_addr,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ADDR_W-1:0]         resp_addr,
  output logic [FETCH_W*INST_W-1:0] resp_data,
  output logic [FETCH_W-1:0]        resp_mask,
  input  logic                      ld_en,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [INST_W-1:0]         ld_data
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int FD    = LAT + 1;
  localparam int NS    = (LAT > 1) ? LAT - 1 : 1;
  localparam int PW    = $clog2(FD);
  localparam int CW    = $clog2(FD + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]         addr;
    logic [FETCH_W*INST_W-1:0] data;
    logic [FETCH_W-1:0]        mask;
  } bundle_t;

  logic [INST_W-1:0] mem [DEPTH];
  logic [CW-1:0]     occ;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [NS-1:0]     vld_pipe;
  logic [ADDR_W:0]   la;
  logic              accept, pop, push;
  bundle_t           acc_b, push_b, head;
  bundle_t           stg  [NS];
  bundle_t           fifo [FD];

  assign req_ready = !rst && !flush && (occ < CW'(FD));
  assign accept    = req_valid && req_ready;
  assign pop       = resp_valid && resp_ready;

  // Array is read combinationally in the accept cycle, so a same-cycle load sees the old word.
  always_comb begin
    acc_b      = '0;
    la         = '0;
    acc_b.addr = req_addr;
    for (int i = 0; i < FETCH_W; i++) begin
      la = {1'b0, req_addr} + (ADDR_W+1)'(i);
      if (WRAP != 0 || !la[ADDR_W]) begin
        acc_b.mask[i] = 1'b1;
        acc_b.data[i*INST_W +: INST_W] = mem[la[ADDR_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // The FIFO write is the last of the LAT stages, so LAT=1 pushes straight from the accept.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int k = 1; k < NS; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
    stg[0] <= acc_b;
    for (int k = 1; k < NS; k++) stg[k] <= stg[k-1];
  end

  assign push   = (LAT == 1) ? accept : vld_pipe[NS-1];
  assign push_b = (LAT == 1) ? acc_b  : stg[NS-1];

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= push_b;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FD-1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FD-1)) ? '0 : rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // occ covers both the pipeline and the FIFO, which is what keeps the FIFO from overflowing.
  always_ff @(posedge clk) begin
    if (rst || flush)        occ <= '0;
    else if (accept && !pop) occ <= occ + CW'(1);
    else if (!accept && pop) occ <= occ - CW'(1);
  end

  assign head       = fifo[rd_ptr];
  assign resp_valid = (cnt != '0);
  assign resp_addr  = resp_valid ? head.addr : '0;
  assign resp_data  = resp_valid ? head.data : '0;
  assign resp_mask  = resp_valid ? head.mask : '0;
endmodule

// File: tb/tb_memi_fetch.sv
// Bench for memi_fetch: WRAP=0 and WRAP=1 instances share stimulus; a queue model
// checks every cycle, and directed steps pin literal values from the test plan.
module tb_memi_fetch;
  localparam int LAT = 2;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, req_valid = 1'b0, resp_ready = 1'b1, ld_en = 1'b0;
  logic [3:0]  req_addr = '0, ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        req_ready0, req_ready1, resp_valid0, resp_valid1;
  logic [3:0]  resp_addr0, resp_addr1;
  logic [31:0] resp_data0, resp_data1;
  logic [1:0]  resp_mask0, resp_mask1;

  int n_chk = 0, n_pass = 0, cyc = 0, nacc = 0;
  bit chk_en = 1'b0;

  memi_fetch #(.INST_W(16), .ADDR_W(4), .FETCH_W(2), .LAT(LAT), .WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready0),
    .req_addr(req_addr), .resp_valid(resp_valid0), .resp_ready(resp_ready),
    .resp_addr(resp_addr0), .resp_data(resp_data0), .resp_mask(resp_mask0),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  memi_fetch #(.INST_W(16), .ADDR_W(4), .FETCH_W(2), .LAT(LAT), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready1),
    .req_addr(req_addr), .resp_valid(resp_valid1), .resp_ready(resp_ready),
    .resp_addr(resp_addr1), .resp_data(resp_data1), .resp_mask(resp_mask1),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model: memory image plus a queue of accepted-but-unpopped bundles with their due cycle.
  typedef struct {
    logic [3:0]  addr;
    logic [31:0] d0, d1;
    logic [1:0]  m0, m1;
    int          due;
  } exp_t;

  logic [15:0] mm [16];
  exp_t        q [$];

  initial for (int i = 0; i < 16; i++) mm[i] = '0;

  always @(negedge clk) begin
    bit   er, ev;
    exp_t n;
    if (chk_en) begin
      er = !rst && !flush && (q.size() < LAT + 1);
      ev = (q.size() > 0) && (q[0].due <= cyc);
      chk("m_req_ready0", 32'(req_ready0), 32'(er));
      chk("m_req_ready1", 32'(req_ready1), 32'(er));
      chk("m_resp_valid0", 32'(resp_valid0), 32'(ev));
      chk("m_resp_valid1", 32'(resp_valid1), 32'(ev));
      if (ev) begin
        chk("m_addr0", 32'(resp_addr0), 32'(q[0].addr));
        chk("m_addr1", 32'(resp_addr1), 32'(q[0].addr));
        chk("m_data0", resp_data0, q[0].d0);
        chk("m_data1", resp_data1, q[0].d1);
        chk("m_mask0", 32'(resp_mask0), 32'(q[0].m0));
        chk("m_mask1", 32'(resp_mask1), 32'(q[0].m1));
      end
      n.addr = req_addr; n.d0 = '0; n.d1 = '0; n.m0 = '0; n.m1 = '0; n.due = cyc + LAT;
      for (int i = 0; i < 2; i++) begin
        int a;
        a = int'(req_addr) + i;
        if (a <= 15) begin
          n.d0[i*16 +: 16] = mm[a];
          n.m0[i] = 1'b1;
        end
        n.d1[i*16 +: 16] = mm[a % 16];
        n.m1[i] = 1'b1;
      end
      if (rst) begin
        q.delete();
        for (int i = 0; i < 16; i++) mm[i] = '0;
      end else begin
        if (flush) q.delete();
        else begin
          if (ev && resp_ready) void'(q.pop_front());
          if (req_valid && er) q.push_back(n);
        end
        if (ld_en) mm[ld_addr] = ld_data;
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [3:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
  endtask

  task automatic req(input logic [3:0] a);
    req_valid = 1'b1; req_addr = a;
  endtask

  initial begin
    // reset
    step(); chk_en = 1'b1;
    @(negedge clk); chk("rst_ready_low", 32'(req_ready0), 0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_high", 32'(req_ready0), 1);
    chk("rst_resp_valid", 32'(resp_valid0), 0);
    chk("rst_resp_addr", 32'(resp_addr0), 0);
    chk("rst_resp_data", resp_data0, 0);
    chk("rst_resp_mask", 32'(resp_mask0), 0);

    // load then fetch
    step(); ld(4'd3, 16'h1111);
    step(); ld(4'd4, 16'h2222);
    step(); ld_en = 1'b0; req(4'd3);
    step(); req_valid = 1'b0;
    step(); @(negedge clk);
    chk("lf_valid", 32'(resp_valid0), 1);
    chk("lf_data", resp_data0, 32'h2222_1111);
    chk("lf_mask", 32'(resp_mask0), 3);
    chk("lf_addr", 32'(resp_addr0), 3);

    // end-of-memory boundary
    step(); ld(4'd0, 16'h5A5A);
    step(); ld(4'd15, 16'hF00F);
    step(); ld_en = 1'b0; req(4'd15);
    step(); req_valid = 1'b0;
    step(); @(negedge clk);
    chk("bnd_mask_nowrap", 32'(resp_mask0), 1);
    chk("bnd_data_nowrap", resp_data0, 32'h0000_F00F);
    chk("bnd_mask_wrap", 32'(resp_mask1), 3);
    chk("bnd_data_wrap", resp_data1, 32'h5A5A_F00F);

    // streaming
    for (int c = 0; c < 12; c++) begin
      step();
      if (c < 10) req(4'(c)); else req_valid = 1'b0;
      @(negedge clk);
      if (c < 10) chk("stream_ready", 32'(req_ready0), 1);
      if (c >= 2) begin
        chk("stream_valid", 32'(resp_valid0), 1);
        chk("stream_addr", 32'(resp_addr0), 32'(c - 2));
      end
    end

    // back-pressure
    nacc = 0;
    for (int c = 0; c < 5; c++) begin
      step(); req(4'(6 + c)); resp_ready = 1'b0;
      @(negedge clk);
      if (req_ready0) nacc++;
      if (c == 4) begin
        chk("bp_ready_low", 32'(req_ready0), 0);
        chk("bp_head_addr", 32'(resp_addr0), 6);
        chk("bp_head_data", resp_data0, 32'h0000_0000);
      end
    end
    chk("bp_accepts", 32'(nacc), 3);
    step(); req_valid = 1'b0; resp_ready = 1'b1;
    step(); resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_back", 32'(req_ready0), 1);
    chk("bp_next_head", 32'(resp_addr0), 7);
    step(); resp_ready = 1'b1;
    repeat (4) step();

    // read/write collision
    step(); ld(4'd5, 16'hAAAA);
    step(); ld(4'd5, 16'hBBBB); req(4'd5);
    step(); ld_en = 1'b0; req(4'd5);
    step(); req_valid = 1'b0;
    @(negedge clk); chk("col_old", 32'(resp_data0[15:0]), 32'hAAAA);
    step(); @(negedge clk); chk("col_new", 32'(resp_data0[15:0]), 32'hBBBB);

    // flush mid-operation
    for (int c = 0; c < 3; c++) begin
      step(); req(4'(c));
    end
    step(); req_valid = 1'b0; flush = 1'b1;
    step(); flush = 1'b0;
    @(negedge clk);
    chk("fl_valid", 32'(resp_valid0), 0);
    chk("fl_ready", 32'(req_ready0), 1);
    repeat (4) begin
      step(); @(negedge clk); chk("fl_quiet", 32'(resp_valid0), 0);
    end

    // reset mid-operation
    step(); ld(4'd2, 16'h1234);
    for (int c = 0; c < 3; c++) begin
      step(); ld_en = 1'b0; req(4'(c));
    end
    step(); req_valid = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("rm_valid", 32'(resp_valid0), 0);
    chk("rm_ready", 32'(req_ready0), 1);
    step(); req(4'd2);
    step(); req_valid = 1'b0;
    step(); @(negedge clk);
    chk("rm_zero_valid", 32'(resp_valid0), 1);
    chk("rm_zero_data", resp_data0, 0);
    chk("rm_zero_mask", 32'(resp_mask0), 3);

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
